// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM state type and the combinational op evaluator.
// Used by the ALU decoder and by multicycle_alu.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_SLTU  = 4'b0101;
   localparam logic [3:0] ALU_XOR   = 4'b0110;
   localparam logic [3:0] ALU_LUI   = 4'b0111;
   localparam logic [3:0] ALU_SLL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_SRL   = 4'b1010;
   localparam logic [3:0] ALU_AUIPC = 4'b1011;

   function automatic logic is_shift(input logic [3:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRA) || (ctrl == ALU_SRL);
   endfunction

   // Shifts use a full barrel shift here; the serial build only calls this with amount 0.
   function automatic logic [31:0] alu_compute(input logic [3:0]  ctrl,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      logic [4:0] shamt;
      shamt = b[4:0];
      case (ctrl)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_SLT:   return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:  return {31'd0, a < b};
         ALU_XOR:   return a ^ b;
         ALU_LUI:   return b;
         ALU_SLL:   return a << shamt;
         ALU_SRA:   return $unsigned($signed(a) >>> shamt);
         ALU_SRL:   return a >> shamt;
         ALU_AUIPC: return a + b;
         default:   return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift step for the serial shifter: left with zero fill, or right with
// zero/sign fill.
module alu_shift_step (
   input  logic [31:0] i_value,
   input  logic        i_left,
   input  logic        i_arith,
   output logic [31:0] o_value
);
   assign o_value = i_left ? {i_value[30:0], 1'b0}
                           : {i_arith & i_value[31], i_value[31:1]};
endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU with valid/ready handshakes; shifts run serially one bit per cycle unless
// MULTICYCLE_ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module multicycle_alu
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  ALU_control,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero
);

   alu_state_t  r_state;
   alu_state_t  w_state_next;
   logic [31:0] r_result;
   logic        w_accept;
   logic        w_serial_start;

   assign w_accept = in_valid && (r_state == ST_IDLE);

`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
   assign w_serial_start = 1'b0;
`else
   logic [4:0]  r_count;
   logic        r_left;
   logic        r_arith;
   logic [31:0] w_step;

   assign w_serial_start = is_shift(ALU_control) && (src_b[4:0] != 5'd0);

   alu_shift_step u_shift_step (
      .i_value (r_result),
      .i_left  (r_left),
      .i_arith (r_arith),
      .o_value (w_step)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = w_serial_start ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
`ifdef MULTICYCLE_ALU_FAST_SHIFT_EN
            w_state_next = ST_DONE;
`else
            // Count of 1 means this cycle's step is the last one.
            if (r_count == 5'd1) begin
               w_state_next = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= 32'd0;
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
         r_count  <= 5'd0;
         r_left   <= 1'b0;
         r_arith  <= 1'b0;
`endif
      end else if (w_accept) begin
         // Serial shifts start from the raw operand; everything else completes here.
         r_result <= w_serial_start ? src_a : alu_compute(ALU_control, src_a, src_b);
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
         r_count  <= src_b[4:0];
         r_left   <= (ALU_control == ALU_SLL);
         r_arith  <= (ALU_control == ALU_SRA);
`endif
      end
`ifndef MULTICYCLE_ALU_FAST_SHIFT_EN
      else if (r_state == ST_SHIFT) begin
         r_result <= w_step;
         r_count  <= r_count - 5'd1;
      end
`endif
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;
   assign zero      = (r_result == 32'd0);

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operation request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port ALU_control, input, 4 bits: operation code from the ALU decoder.
REQ-006 SHALL have ports src_a and src_b, input, 32 bits each: operands.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-009 SHALL have port result, output, 32 bits: operation result.
REQ-010 SHALL have port zero, output, 1 bit: high iff result == 0, qualified by out_valid.

Function
REQ-011 SHALL treat a request as accepted in any cycle with in_valid && in_ready, and latch ALU_control, src_a and src_b that cycle.
REQ-012 SHALL decode codes as follows:
- 0000 add
- 0001 sub
- 0010 and
- 0011 or
- 0100 slt (signed, result 1/0)
- 0101 sltu
- 0110 xor
- 0111 lui (result = src_b)
- 1000 sll
- 1001 sra
- 1010 srl
- 1011 auipc (result = src_a + src_b)
- 1100-1111 result 0
REQ-013 SHALL wrap add/sub/auipc modulo 2^32; shift amount = src_b[4:0], upper bits ignored.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready high only in IDLE; one operation in flight.
REQ-015 SHALL transition as follows:
- IDLE -> DONE on accepting a non-shift operation or a shift with amount 0.
- IDLE -> SHIFT on accepting a shift with amount > 0.
REQ-016 SHALL in SHIFT move the working value one bit per cycle, decrement the remaining count, and go to DONE on the cycle the count reaches 0.
REQ-017 SHALL fill with 0 for sll/srl and replicate bit 31 for sra on each step.
REQ-018 SHALL assert out_valid only in DONE and hold result/zero stable until out_valid && out_ready, then return to IDLE.
REQ-019 SHALL give latency = 1 cycle from acceptance to out_valid for non-shifts, and 1 + amount cycles for shifts.
REQ-020 SHALL ignore in_valid while not in IDLE, and ignore out_ready while not in DONE.

Reset
REQ-021 SHALL on reset assertion force state IDLE, out_valid 0, result 0, and clear the shift count, independent of clk.
REQ-022 SHALL give in_ready = 1 and zero = 1 during and after reset.
REQ-023 SHALL abort any in-progress operation on reset mid-operation with no result produced.

Configuration
REQ-024 SHALL with macro MULTICYCLE_ALU_FAST_SHIFT_EN defined implement shifts with a single-cycle barrel shifter; all shifts then follow the IDLE -> DONE path with latency 1.
REQ-025 SHALL without MULTICYCLE_ALU_FAST_SHIFT_EN use the serial SHIFT behaviour of REQ-016/REQ-017.

Structure
REQ-026 SHALL take ALU control code constants and the FSM state enum typedef from shared package alu_pkg, which the ALU decoder also uses.
REQ-027 SHALL place the one-bit shift step (direction, arithmetic select) in sub-module alu_shift_step, instantiated only in the serial configuration.

Verification
REQ-028 Add: code 0000, src_a = 0xFFFFFFFF, src_b = 1 -> out_valid 1 cycle after acceptance, result 0, zero 1.
REQ-029 Serial sra: code 1001, src_a = 0x80000000, src_b = 0x24 (amount 4) -> out_valid 5 cycles after acceptance, result 0xF8000000.
REQ-030 Backpressure: result ready, out_ready held 0 for 3 cycles -> result stable, in_ready 0 throughout; accept on the 4th cycle -> in_ready 1 the next cycle.
REQ-031 slt/sltu: src_a = 0xFFFFFFFF, src_b = 1 -> slt result 1, sltu result 0.
REQ-032 Reset mid-shift: sll with amount 20, reset asserted after 5 cycles -> out_valid 0 and in_ready 1 immediately; no result emitted.
REQ-033 Fast-shift build: srl with amount 31 on 0x80000000 -> result 1, 1 cycle after acceptance.
